// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit with the MEM/WB pipeline register.
// Keeps one data-memory access in flight, stalling upstream and bubbling W meanwhile.
module mem_stage_lsu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [WIDTH-1:0] PCPlus4M,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic             ResultSrcM,
    input  logic             WDMEM,
    input  logic             WD3SrcM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             stall_o,
    output logic [WIDTH-1:0] ALUResultW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] PCPlus4W,
    output logic [4:0]       RdW,
    output logic             RegWriteW,
    output logic             ResultSrcW,
    output logic             WD3SrcW
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             memop;
    logic             stall_c;
    logic             capture;
    logic             take_rdata;

    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic [WIDTH-1:0] read_data_q,  read_data_d;
    logic [WIDTH-1:0] pc_plus4_q,   pc_plus4_d;
    logic [4:0]       rd_q,         rd_d;
    logic             reg_write_q,  reg_write_d;
    logic             result_src_q, result_src_d;
    logic             wd3_src_q,    wd3_src_d;

    // Next state plus stall/capture decision; a non-captured cycle is a W bubble.
    always_comb begin
        state_d    = state_q;
        stall_c    = 1'b0;
        capture    = 1'b0;
        take_rdata = 1'b0;
        memop      = ResultSrcM | WDMEM;

        case (state_q)
            S_IDLE: begin
                if (memop) begin
                    stall_c = 1'b1;
                    state_d = S_REQ;
                end else begin
                    capture = 1'b1;
                end
            end
            S_REQ: begin
                if (!mem_gnt) begin
                    stall_c = 1'b1;
                end else if (ResultSrcM) begin
                    stall_c = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    capture    = 1'b1;
                    take_rdata = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        alu_result_d = '0;
        read_data_d  = '0;
        pc_plus4_d   = '0;
        rd_d         = '0;
        reg_write_d  = 1'b0;
        result_src_d = 1'b0;
        wd3_src_d    = 1'b0;
        if (capture) begin
            alu_result_d = ALUResultM;
            read_data_d  = take_rdata ? mem_rdata : '0;
            pc_plus4_d   = PCPlus4M;
            rd_d         = RdM;
            reg_write_d  = RegWriteM;
            result_src_d = ResultSrcM;
            wd3_src_d    = WD3SrcM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            wd3_src_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            wd3_src_q    <= wd3_src_d;
        end
    end

    // Request side is combinational; gating with rst_n drops it the instant reset hits.
    assign stall_o   = rst_n & stall_c;
    assign mem_req   = rst_n & (state_q == S_REQ);
    assign mem_we    = mem_req & WDMEM & ~ResultSrcM;
    assign mem_addr  = {ALUResultM[WIDTH-1:2], 2'b00};
    assign mem_wdata = WriteDataM;

    assign ALUResultW = alu_result_q;
    assign ReadDataW  = read_data_q;
    assign PCPlus4W   = pc_plus4_q;
    assign RdW        = rd_q;
    assign RegWriteW  = reg_write_q;
    assign ResultSrcW = result_src_q;
    assign WD3SrcW    = wd3_src_q;

endmodule
